ale_frame_sequencer: RTL and testbench
======================================

# ale_frame_sequencer

Frame-level controller that sequences the two-pass haze-removal flow around the atmospheric light estimator. It clears the estimator, then streams one full frame of 3x3 windows into it (pass 1). It waits for the estimator pipeline to drain, latches the final atmospheric light and reciprocal values, and then streams the frame a second time to the recovery datapath (pass 2) with row/column tags. It sits between the line-buffer/window generator (pixel source), the estimator and the transmission/recovery stages.

## Interface
Parameters:
- IMG_W, 512, frame width in pixels
- IMG_H, 512, frame height in pixels
- ALE_LATENCY, 3, drain cycles between the last pass-1 transfer and sampling of estimator outputs (>=1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  frame request, sampled only in IDLE
- reuse_a  in  1  skip pass 1 and reuse latched A (honoured only with SEQ_REUSE_A_EN)
- pix_valid  in  1  window source has a valid 3x3 window
- pix_ready  out  1  sequencer accepts a window this cycle
- ale_rst  out  1  clear pulse to estimator
- ale_valid  out  1  input_valid to estimator
- ale_a_r/g/b  in  8 each  estimator atmospheric light outputs
- ale_inv_r/g/b  in  10 each  estimator reciprocal outputs
- a_r/g/b  out  8 each  latched atmospheric light
- inv_a_r/g/b  out  10 each  latched reciprocals
- a_valid  out  1  latched values are valid
- out_valid  out  1  pass-2 window accepted, qualifies recovery datapath
- out_col  out  $clog2(IMG_W)  column of current pass-2 transfer
- out_row  out  $clog2(IMG_H)  row of current pass-2 transfer
- out_last  out  1  high with out_valid on the final pixel of a frame
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, CLEAR, PASS1, DRAIN, LATCH, PASS2, DONE.
- IDLE:
  - start=1 moves to CLEAR.
  - With SEQ_REUSE_A_EN, start=1 and reuse_a=1 and a_valid=1 moves directly to PASS2.
- CLEAR:
  - ale_rst=1 for exactly this one cycle.
  - Moves to PASS1.
- PASS1:
  - pix_ready=1.
  - A transfer is pix_valid & pix_ready; ale_valid equals the transfer, combinationally.
  - col increments per transfer and wraps to 0 at IMG_W-1, at which point row increments.
  - A transfer at col=IMG_W-1 and row=IMG_H-1 clears both counters and moves to DRAIN.
- DRAIN:
  - pix_ready=0.
  - Drain counter runs for ALE_LATENCY cycles, then moves to LATCH.
- LATCH:
  - a_r/g/b and inv_a_r/g/b register ale_a_* and ale_inv_* on this cycle's edge.
  - a_valid set to 1.
  - Moves to PASS2.
- PASS2:
  - Same handshake and counters as PASS1, but drives out_valid instead of ale_valid.
  - out_col/out_row show the counter values of the current transfer.
  - out_last = out_valid at the final coordinate.
  - Final transfer moves to DONE.
- DONE:
  - done=1 for one cycle.
  - Moves to IDLE.
- Latched values hold until the next LATCH or rst. Estimator output changes outside LATCH have no effect.
- start outside IDLE is ignored. It is not queued; start high during DONE is also ignored.
- ale_valid and out_valid are never both high, and never high outside PASS1/PASS2.
- pix_valid dropping mid-pass stalls the counters; there is no timeout.

## Timing
- Reset values: state IDLE, counters 0, pix_ready 0, ale_rst 0, ale_valid 0, out_valid 0, out_last 0, a_* 0, inv_a_* 0, a_valid 0, busy 0, done 0.
- rst mid-operation returns everything to the reset values on the next edge; the partial frame is discarded.
- pix_ready, ale_valid, out_valid and out_last are Moore/combinational from registered state and counters plus pix_valid. All other outputs are registered.
- Full flow with pix_valid held at 1, measured in cycles from the start edge to the done pulse:
  - 1 (CLEAR) + IMG_W*IMG_H (PASS1) + ALE_LATENCY + 1 (LATCH) + IMG_W*IMG_H (PASS2), with done high in the following cycle.
- Reuse path: PASS2 begins the cycle after start is sampled.
- busy is high from the cycle after start is sampled through the DONE cycle, and low once back in IDLE.

## Configuration
- SEQ_REUSE_A_EN defined:
  - The IDLE reuse_a branch is compiled in, for video use with A carried between frames.
  - Pass 1, CLEAR and DRAIN are skipped when a_valid=1.
  - When a_valid=0, the full flow runs regardless of reuse_a.
- Not defined:
  - reuse_a is ignored and every start runs the full flow.

## Test plan
- IMG_W=IMG_H=4, ALE_LATENCY=3, pix_valid=1, start pulse:
  - ale_rst high 1 cycle, then ale_valid high 16 consecutive cycles.
  - 3 idle cycles, then LATCH captures ale_a_r=0xC8, ale_inv_r=0x147.
  - 16 out_valid cycles with out_last on (row 3, col 3).
  - done pulse exactly 38 cycles after the start edge.
- pix_valid toggling 1,0,1,0:
  - Each pass takes 31 cycles; counters advance only on transfers.
  - out_col/out_row sequence is (0,0),(1,0)…(3,3).
- start pulses during PASS1 and during DONE: no restart; exactly one done pulse per accepted start.
- rst asserted mid-PASS2 after A was latched: next cycle busy=0, a_valid=0, a_r=0, inv_a_r=0, pix_ready=0.
- ale_a_* changed every cycle after LATCH: a_r/g/b and inv_a_* remain at their LATCH-cycle values through DONE.
- SEQ_REUSE_A_EN defined:
  - Second start with reuse_a=1: no ale_rst or ale_valid, out_valid begins next cycle, done after 17 cycles.
  - start with reuse_a=1 after rst: full 38-cycle flow.

Source files
------------

// File: rtl/ale_seq_if.sv
// Handshake and data bundle between the frame sequencer, its window source,
// the atmospheric light estimator and the recovery stages.
interface ale_seq_if #(
  parameter int unsigned IMG_W = 512,
  parameter int unsigned IMG_H = 512
);
  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic          start;
  logic          reuse_a;
  logic          pix_valid;
  logic          pix_ready;
  logic          ale_rst;
  logic          ale_valid;
  logic [7:0]    ale_a_r, ale_a_g, ale_a_b;
  logic [9:0]    ale_inv_r, ale_inv_g, ale_inv_b;
  logic [7:0]    a_r, a_g, a_b;
  logic [9:0]    inv_a_r, inv_a_g, inv_a_b;
  logic          a_valid;
  logic          out_valid;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic          out_last;
  logic          busy;
  logic          done;

  // Sequencer side
  modport master (
    input  start, reuse_a, pix_valid,
    input  ale_a_r, ale_a_g, ale_a_b, ale_inv_r, ale_inv_g, ale_inv_b,
    output pix_ready, ale_rst, ale_valid,
    output a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b, a_valid,
    output out_valid, out_col, out_row, out_last, busy, done
  );

  // Surrounding pipeline side
  modport slave (
    output start, reuse_a, pix_valid,
    output ale_a_r, ale_a_g, ale_a_b, ale_inv_r, ale_inv_g, ale_inv_b,
    input  pix_ready, ale_rst, ale_valid,
    input  a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b, a_valid,
    input  out_valid, out_col, out_row, out_last, busy, done
  );
endinterface

// File: rtl/ale_frame_sequencer.sv
// Two-pass frame controller around the atmospheric light estimator.
// Optional SEQ_REUSE_A_EN lets a start skip pass 1 and reuse the latched A.
module ale_frame_sequencer #(
  parameter int unsigned IMG_W       = 512,
  parameter int unsigned IMG_H       = 512,
  parameter int unsigned ALE_LATENCY = 3
) (
  input  logic       clk,
  input  logic       rst,
  ale_seq_if.master  bus
);
  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned DW = (ALE_LATENCY > 1) ? $clog2(ALE_LATENCY) : 1;
  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H - 1);
  localparam logic [DW-1:0] DRAIN_MAX = DW'(ALE_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_PASS1, S_DRAIN, S_LATCH, S_PASS2, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] drain_cnt;
  logic          in_pass_c, xfer_c, last_px_c, reuse_ok_c;

`ifdef SEQ_REUSE_A_EN
  assign reuse_ok_c = bus.reuse_a & bus.a_valid;
`else
  logic unused_reuse_a;
  assign unused_reuse_a = bus.reuse_a;
  assign reuse_ok_c     = 1'b0;
`endif

  assign in_pass_c = (state == S_PASS1) || (state == S_PASS2);
  assign xfer_c    = in_pass_c & bus.pix_valid;
  assign last_px_c = (col == COL_MAX) && (row == ROW_MAX);
  assign bus.out_col = col;
  assign bus.out_row = row;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and the handshake outputs that must follow pix_valid in-cycle
  always_comb begin
    state_nxt     = state;
    bus.pix_ready = 1'b0;
    bus.ale_valid = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = reuse_ok_c ? S_PASS2 : S_CLEAR;
      S_CLEAR: state_nxt = S_PASS1;
      S_PASS1: begin
        bus.pix_ready = 1'b1;
        bus.ale_valid = bus.pix_valid;
        if (bus.pix_valid && last_px_c) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (drain_cnt == DRAIN_MAX) state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_PASS2;
      S_PASS2: begin
        bus.pix_ready = 1'b1;
        bus.out_valid = bus.pix_valid;
        bus.out_last  = bus.pix_valid & last_px_c;
        if (bus.pix_valid && last_px_c) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Raster counters advance only on accepted windows; the final pixel wraps both
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (xfer_c) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != S_DRAIN) drain_cnt <= '0;
    else                         drain_cnt <= drain_cnt + 1'b1;
  end

  // Registered status and the latched estimator results
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ale_rst <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.a_valid <= 1'b0;
      bus.a_r     <= '0;
      bus.a_g     <= '0;
      bus.a_b     <= '0;
      bus.inv_a_r <= '0;
      bus.inv_a_g <= '0;
      bus.inv_a_b <= '0;
    end else begin
      bus.ale_rst <= (state_nxt == S_CLEAR);
      bus.busy    <= (state_nxt != S_IDLE);
      bus.done    <= (state_nxt == S_DONE);
      if (state == S_LATCH) begin
        bus.a_valid <= 1'b1;
        bus.a_r     <= bus.ale_a_r;
        bus.a_g     <= bus.ale_a_g;
        bus.a_b     <= bus.ale_a_b;
        bus.inv_a_r <= bus.ale_inv_r;
        bus.inv_a_g <= bus.ale_inv_g;
        bus.inv_a_b <= bus.ale_inv_b;
      end
    end
  end
endmodule

// File: tb/tb_ale_frame_sequencer.sv
// Scoreboard bench for ale_frame_sequencer on a 4x4 frame with a 3-cycle drain.
module tb_ale_frame_sequencer;
  localparam int unsigned W   = 4;
  localparam int unsigned H   = 4;
  localparam int unsigned LAT = 3;

  typedef logic [4:0] tag_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ale_seq_if #(.IMG_W(W), .IMG_H(H)) bus ();

  ale_frame_sequencer #(.IMG_W(W), .IMG_H(H), .ALE_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          n_done   = 0;
  int          n_rst    = 0;
  int          n_alev   = 0;
  int          done_cyc = 0;
  tag_t        exp_q[$];
  logic [23:0] exp_a    = '0;
  logic [29:0] exp_inv  = '0;

  function automatic void chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every pass-2 transfer
  always @(negedge clk) begin
    tag_t e;
    if (bus.ale_rst)   n_rst++;
    if (bus.ale_valid) n_alev++;
    if (bus.done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (bus.ale_valid || bus.out_valid)
      chk("valid_exclusive", int'(bus.ale_valid & bus.out_valid), 0);
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_last_row_col", int'({bus.out_last, bus.out_row, bus.out_col}), int'(e));
        chk("a_during_pass2", int'({bus.a_r, bus.a_g, bus.a_b}), int'(exp_a));
        chk("inv_during_pass2", int'({bus.inv_a_r, bus.inv_a_g, bus.inv_a_b}), int'(exp_inv));
      end
    end
  end

  // One frame request; exp_done/exp_latch are cycle indices counted from the start edge
  task automatic run_frame(input bit tog, input bit reuse, input bit pulses,
                           input int exp_done, input int exp_latch, input int abort_k,
                           input bit full, input logic [23:0] a_new, input logic [29:0] inv_new);
    int t0, d0, r0, v0;
    bit ph;
    if (full) begin
      exp_a   = a_new;
      exp_inv = inv_new;
    end
    for (int r = 0; r < int'(H); r++)
      for (int c = 0; c < int'(W); c++)
        exp_q.push_back({(r == int'(H) - 1 && c == int'(W) - 1), 2'(r), 2'(c)});
    d0 = n_done;
    r0 = n_rst;
    v0 = n_alev;
    t0 = cyc;
    ph = 1'b1;
    bus.start     = 1'b1;
    bus.reuse_a   = reuse;
    bus.pix_valid = 1'b1;
    for (int k = 1; k <= exp_done + 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) t0 = cyc;
      bus.start   = pulses && (k == 5 || k == exp_done);
      bus.reuse_a = 1'b0;
      if (tog) begin
        ph = bus.pix_ready ? ~ph : 1'b1;
        bus.pix_valid = ~ph;
      end
      {bus.ale_a_r, bus.ale_a_g, bus.ale_a_b} = (k == exp_latch) ? a_new : a_new ^ 24'({k, 1'b1});
      {bus.ale_inv_r, bus.ale_inv_g, bus.ale_inv_b} =
        (k == exp_latch) ? inv_new : inv_new ^ 30'({k, 1'b1});
      if (k == 1) begin
        chk("busy_after_start", bus.busy, 1);
        chk("ale_rst_first_cycle", bus.ale_rst, full ? 1 : 0);
      end
      if (k == exp_done && abort_k == 0) chk("busy_in_done", bus.busy, 1);
      if (abort_k != 0 && k == abort_k) rst = 1'b1;
      if (abort_k != 0 && k == abort_k + 1) begin
        rst = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_a_valid", bus.a_valid, 0);
        chk("abort_a_r", bus.a_r, 0);
        chk("abort_inv_a_r", bus.inv_a_r, 0);
        chk("abort_pix_ready", bus.pix_ready, 0);
        exp_q.delete();
        exp_a   = '0;
        exp_inv = '0;
        return;
      end
    end
    chk("done_count", n_done - d0, 1);
    chk("done_cycle", done_cyc - t0 + 1, exp_done);
    chk("ale_rst_count", n_rst - r0, full ? 1 : 0);
    chk("ale_valid_count", n_alev - v0, full ? int'(W * H) : 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("busy_back_idle", bus.busy, 0);
    chk("a_valid_set", bus.a_valid, 1);
    chk("a_held_after_done", int'({bus.a_r, bus.a_g, bus.a_b}), int'(exp_a));
    chk("inv_held_after_done", int'({bus.inv_a_r, bus.inv_a_g, bus.inv_a_b}), int'(exp_inv));
    exp_q.delete();
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.reuse_a   = 1'b0;
    bus.pix_valid = 1'b0;
    {bus.ale_a_r, bus.ale_a_g, bus.ale_a_b}       = '0;
    {bus.ale_inv_r, bus.ale_inv_g, bus.ale_inv_b} = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_pix_ready", bus.pix_ready, 0);
    chk("rst_ale_rst", bus.ale_rst, 0);
    chk("rst_ale_valid", bus.ale_valid, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_a_valid", bus.a_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_a", int'({bus.a_r, bus.a_g, bus.a_b}), 0);
    chk("rst_counters", int'({bus.out_row, bus.out_col}), 0);
    @(posedge clk); #1;

    // Continuous pix_valid: 1 + 16 + 3 + 1 + 16, done in cycle 38, LATCH in cycle 21
    run_frame(1'b0, 1'b0, 1'b0, 38, 21, 0, 1'b1, 24'hC8A53C, {10'h147, 10'h18C, 10'h2F1});
    // Alternating pix_valid: each pass 31 cycles, LATCH in cycle 36, done in cycle 68
    run_frame(1'b1, 1'b0, 1'b0, 68, 36, 0, 1'b1, 24'h1F7E90, {10'h3FF, 10'h201, 10'h0AA});
    // Stray starts in PASS1 and in DONE are ignored
    run_frame(1'b0, 1'b0, 1'b1, 38, 21, 0, 1'b1, 24'h5566EE, {10'h111, 10'h222, 10'h333});
`ifdef SEQ_REUSE_A_EN
    run_frame(1'b0, 1'b1, 1'b0, 17, 0, 0, 1'b0, 24'h000000, 30'h0);
`else
    run_frame(1'b0, 1'b1, 1'b0, 38, 21, 0, 1'b1, 24'hABCDEF, {10'h155, 10'h2AA, 10'h0F0});
`endif
    // Reset in the middle of PASS2 (cycle 30) discards A
    run_frame(1'b0, 1'b0, 1'b0, 38, 21, 30, 1'b1, 24'h0102FF, {10'h007, 10'h1C0, 10'h300});
    @(posedge clk); #1;
    // reuse_a with nothing latched runs the full flow in either build
    run_frame(1'b0, 1'b1, 1'b0, 38, 21, 0, 1'b1, 24'h7F8081, {10'h0C8, 10'h064, 10'h3E8});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
